// File: rtl/pipe_slice.sv
// pipe_slice: DEPTH-stage elastic register slice built from two-entry skid buffers.
// Every output, in_ready included, comes straight from a flop.
module pipe_slice #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WIDTH-1:0]                 in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WIDTH-1:0]                 out_data,
    output logic [$clog2(2*DEPTH+1)-1:0]     count
);
    localparam int CW = $clog2(2 * DEPTH + 1);

    if (DEPTH < 1) begin : g_bad_depth
        $error("pipe_slice: DEPTH must be >= 1");
    end

    logic [DEPTH-1:0] r_main_v, r_skid_v;
    logic [WIDTH-1:0] r_main_d [DEPTH];
    logic [WIDTH-1:0] r_skid_d [DEPTH];
    logic [CW-1:0]    r_count;
    logic [DEPTH-1:0] w_in_v, w_dn_rdy, w_acc, w_drain;
    logic [WIDTH-1:0] w_in_d [DEPTH];

    // Stage k is fed by stage k-1 and backpressured by the skid of stage k+1.
    assign w_in_v   = DEPTH'({r_main_v, in_valid});
    assign w_dn_rdy = DEPTH'({out_ready, ~r_skid_v} >> 1);
    assign w_acc    = w_in_v & ~r_skid_v;
    assign w_drain  = r_main_v & w_dn_rdy;

    always_comb begin
        w_in_d[0] = in_data;
        for (int k = 1; k < DEPTH; k++) w_in_d[k] = r_main_d[k-1];
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_main_v <= '0;
            r_skid_v <= '0;
            r_count  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_main_d[k] <= RESET_VAL;
                r_skid_d[k] <= RESET_VAL;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (r_main_v[k] && !w_drain[k]) begin
                    if (w_acc[k]) begin
                        r_skid_d[k] <= w_in_d[k];
                        r_skid_v[k] <= 1'b1;
                    end
                end else if (r_skid_v[k]) begin
                    r_main_d[k] <= r_skid_d[k];
                    r_main_v[k] <= 1'b1;
                    r_skid_v[k] <= 1'b0;
                end else begin
                    r_main_v[k] <= w_acc[k];
                    if (w_acc[k]) r_main_d[k] <= w_in_d[k];
                end
            end
            r_count <= r_count + CW'(w_acc[0]) - CW'(w_drain[DEPTH-1]);
        end
    end

    assign in_ready  = ~r_skid_v[0];
    assign out_valid = r_main_v[DEPTH-1];
    assign out_data  = r_main_d[DEPTH-1];
    assign count     = r_count;

    assert property (@(posedge clk) disable iff (rst || flush)
        in_valid && !in_ready |=> in_valid && $stable(in_data));
    assert property (@(posedge clk) disable iff (rst) r_count <= CW'(2 * DEPTH));
endmodule
